// File: rtl/mac_seq.sv
// mac_seq: runs one dot-product job over two operand buffers and returns
// bias + sum((in_byte + offset) * flt_byte) over a valid/ready result port.

// One byte lane of the MAC: (signed input byte + offset) * signed filter byte.
module mac_lane (
  input  logic        i_in,
  input  logic [7:0]  i_in_b,
  input  logic [7:0]  i_flt_b,
  input  logic        i_layer1,
  output logic [17:0] o_prod
);
  logic signed [9:0]  w_a;
  logic signed [17:0] w_a18;
  logic signed [17:0] w_f18;

  // Offset is -83 for the first layer, +128 otherwise; disabled lanes give 0.
  always_comb begin
    w_a    = 10'($signed(i_in_b)) + (i_layer1 ? -10'sd83 : 10'sd128);
    w_a18  = 18'(w_a);
    w_f18  = 18'($signed(i_flt_b));
    o_prod = i_in ? 18'(w_a18 * w_f18) : '0;
  end
endmodule

module mac_seq #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_in_base,
  input  logic [ADDR_W-1:0] start_flt_base,
  input  logic [ADDR_W-1:0] start_len,
  input  logic [31:0]       start_bias,
  input  logic              start_layer1,
  input  logic              start_simd,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] flt_addr,
  input  logic [31:0]       in_data,
  input  logic [31:0]       flt_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              busy
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                           r_state, w_nxt;
  logic [ADDR_W-1:0]                r_in_addr, r_flt_addr, r_cnt;
  logic [31:0]                      r_acc;
  logic                             r_layer1, r_simd, r_vld;
  logic                             w_accept, w_abort;
  logic [NUM_LANES-1:0][17:0]       w_prod;
  logic [31:0]                      w_mac;

  assign w_accept = start_valid && (r_state == S_IDLE);
  // abort only matters while reads or their data are in flight
  assign w_abort  = abort && (r_state == S_RUN || r_state == S_DRAIN);

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      mac_lane u_lane (
        .i_in     (r_simd || (l == 0)),
        .i_in_b   (in_data[8*l +: 8]),
        .i_flt_b  (flt_data[8*l +: 8]),
        .i_layer1 (r_layer1),
        .o_prod   (w_prod[l])
      );
    end
  endgenerate

  // Accumulate all lane products onto the current accumulator (wraps mod 2^32).
  always_comb begin
    w_mac = r_acc;
    for (int l = 0; l < NUM_LANES; l++) w_mac = w_mac + 32'($signed(w_prod[l]));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_nxt       = r_state;
    start_ready = 1'b0;
    rd_en       = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) w_nxt = (start_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        rd_en = 1'b1;
        if (abort)                    w_nxt = S_IDLE;
        else if (r_cnt == ADDR_W'(1)) w_nxt = S_DRAIN;
      end
      S_DRAIN: w_nxt = abort ? S_IDLE : S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Job latch, address/count stepping, read-valid pipe and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_addr  <= '0;
      r_flt_addr <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_layer1   <= 1'b0;
      r_simd     <= 1'b0;
      r_vld      <= 1'b0;
    end else begin
      r_vld <= rd_en && !w_abort;
      if (w_accept) begin
        r_in_addr  <= start_in_base;
        r_flt_addr <= start_flt_base;
        r_cnt      <= start_len;
        r_layer1   <= start_layer1;
        r_simd     <= start_simd;
        r_acc      <= start_bias;
      end else begin
        if (rd_en && !w_abort) begin
          r_in_addr  <= r_in_addr + ADDR_W'(1);
          r_flt_addr <= r_flt_addr + ADDR_W'(1);
          r_cnt      <= r_cnt - ADDR_W'(1);
        end
        if (r_vld && !w_abort) r_acc <= w_mac;
      end
    end
  end

  assign in_addr  = r_in_addr;
  assign flt_addr = r_flt_addr;
  assign res_data = r_acc;
endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: driver pushes expected results/addresses into queues,
// a negedge monitor pops and compares whenever the DUT reads or presents a result.
module tb_mac_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_valid = 1'b0, start_ready;
  logic [9:0]  start_in_base = '0, start_flt_base = '0, start_len = '0;
  logic [31:0] start_bias = '0;
  logic        start_layer1 = 1'b0, start_simd = 1'b0, abort = 1'b0;
  logic        rd_en;
  logic [9:0]  in_addr, flt_addr;
  logic [31:0] in_data = '0, flt_data = '0;
  logic        res_valid, res_ready = 1'b0, busy;
  logic [31:0] res_data;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sq[$];
  logic [9:0]  aq_in[$], aq_flt[$];
  logic [31:0] mem_in [1024];
  logic [31:0] mem_flt[1024];
  int          checks = 0, errors = 0, cyc = 0;
  bit          chk_addr = 1'b1;
  bit          prev_v = 1'b0;
  logic [31:0] prev_d = '0;

  mac_seq #(.ADDR_W(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_in_base(start_in_base), .start_flt_base(start_flt_base),
    .start_len(start_len), .start_bias(start_bias),
    .start_layer1(start_layer1), .start_simd(start_simd), .abort(abort),
    .rd_en(rd_en), .in_addr(in_addr), .flt_addr(flt_addr),
    .in_data(in_data), .flt_data(flt_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // cycle counter for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // operand buffers with one-cycle read latency
  always @(posedge clk) if (rd_en) begin
    in_data  <= mem_in[in_addr];
    flt_data <= mem_flt[flt_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // reference: bias + sum over words and enabled byte lanes of (in+offset)*flt
  function automatic logic [31:0] ref_mac(input int inb, input int fb, input int len,
                                          input logic [31:0] bias, input bit l1, input bit simd);
    logic [31:0] acc = bias;
    logic [31:0] wi, wf;
    int a, f;
    for (int k = 0; k < len; k++) begin
      wi = mem_in[(inb + k) % 1024];
      wf = mem_flt[(fb + k) % 1024];
      for (int l = 0; l < (simd ? 4 : 1); l++) begin
        a = int'($signed(wi[8*l +: 8]));
        f = int'($signed(wf[8*l +: 8]));
        acc = acc + 32'((a + (l1 ? -83 : 128)) * f);
      end
    end
    return acc;
  endfunction

  // monitor: address stream, result handshake, latency and hold stability
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (rd_en && chk_addr) begin
        if (aq_in.size() == 0) chk("unexpected_read", 32'(rd_en), 32'd0);
        else begin
          chk("in_addr", 32'(in_addr), 32'(aq_in.pop_front()));
          chk("flt_addr", 32'(flt_addr), 32'(aq_flt.pop_front()));
        end
      end
      if (res_valid) begin
        if (sq.size() == 0) chk("unexpected_result", 32'(res_valid), 32'd0);
        else begin
          if (!prev_v) chk("latency", 32'(cyc - sq[0].acc_cyc + 1), 32'(sq[0].lat));
          else         chk("hold_data", res_data, prev_d);
          chk("done_start_ready", 32'(start_ready), 32'd0);
          chk("done_rd_en", 32'(rd_en), 32'd0);
          if (res_ready) chk("res_data", res_data, sq.pop_front().data);
        end
      end
      prev_v = res_valid && !res_ready;
      prev_d = res_data;
    end
  end

  task automatic job(input int inb, input int fb, input int len, input logic [31:0] bias,
                     input bit l1, input bit simd, input int dly);
    exp_t e;
    int n;
    start_in_base  = 10'(inb);
    start_flt_base = 10'(fb);
    start_len      = 10'(len);
    start_bias     = bias;
    start_layer1   = l1;
    start_simd     = simd;
    start_valid    = 1'b1;
    e.data = ref_mac(inb, fb, len, bias, l1, simd);
    e.lat  = (len == 0) ? 1 : len + 2;
    for (int k = 0; k < len; k++) begin
      aq_in.push_back(10'((inb + k) % 1024));
      aq_flt.push_back(10'((fb + k) % 1024));
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    e.acc_cyc = cyc;
    sq.push_back(e);
    n = 0;
    while (!res_valid && n < len + 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) begin
      chk("result_timeout", 32'(res_valid), 32'd1);
      sq.delete();
    end
    repeat (dly) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_after_result", {30'd0, start_ready, busy}, 32'd2);
  endtask

  task automatic fill(input int inb, input int fb, input int len,
                      input logic [31:0] vi, input logic [31:0] vf);
    for (int k = 0; k < len; k++) begin
      mem_in[(inb + k) % 1024]  = vi;
      mem_flt[(fb + k) % 1024]  = vf;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_in[i]  = $urandom;
      mem_flt[i] = $urandom;
    end
    #12;
    chk("rst_outputs", {27'd0, start_ready, rd_en, res_valid, busy, 1'b0}, 32'h10);
    chk("rst_addr", {12'd0, in_addr, flt_addr}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    fill(10, 20, 1, 32'h5, 32'h2);
    job(10, 20, 1, 32'd0, 1'b0, 1'b0, 0);
    fill(30, 40, 2, 32'h01010101, 32'h01010101);
    job(30, 40, 2, 32'd10, 1'b0, 1'b1, 1);
    fill(10'h3FE, 100, 4, 32'h53535353, 32'h7F80FF01);
    job(10'h3FE, 100, 4, 32'h12345678, 1'b1, 1'b1, 0);
    job(200, 300, 0, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    job(500, 1020, 6, 32'h7FFFFFF0, 1'b0, 1'b1, 5);

    // abort on cycle 3 of a len=8 job: no result, back to idle
    chk_addr = 1'b0;
    start_in_base = 10'd50; start_flt_base = 10'd60; start_len = 10'd8;
    start_bias = 32'h1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {29'd0, start_ready, busy, rd_en}, 32'h4);
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_no_result", 32'(res_valid), 32'd0);

    // async reset mid-job: immediate reset values, no result
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {28'd0, start_ready, rd_en, res_valid, busy}, 32'h8);
    chk("midrst_state", {2'd0, in_addr, flt_addr, 10'd0} | 32'(res_data != 0), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("midrst_no_result", 32'(res_valid), 32'd0);
    aq_in.delete(); aq_flt.delete();
    chk_addr = 1'b1;

    job(50, 60, 8, 32'h1, 1'b0, 1'b1, 2);

    // randomized jobs
    for (int t = 0; t < 25; t++)
      job($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 12),
          $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 3));

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_empty", 32'(sq.size() + aq_in.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
